// File: rtl/darkroom_pkg.sv
// Shared register map, field layout and pulse-record type for the darkroom decoder.
package darkroom_pkg;

  localparam logic [5:0] ADDR_STATUS    = 6'd0;
  localparam logic [5:0] ADDR_HEAD_TS   = 6'd1;
  localparam logic [5:0] ADDR_HEAD_INFO = 6'd2;
  localparam logic [5:0] ADDR_ENABLE    = 6'd3;
  localparam logic [5:0] ADDR_CH_OVF    = 6'd4;
  localparam logic [5:0] ADDR_IRQ_LEVEL = 6'd5;
  localparam logic [5:0] ADDR_TIMER     = 6'd6;

  localparam int LEVEL_W      = 9;
  localparam int FIFO_OVF_BIT = 31;
  localparam int WIDTH_LSB    = 0;
  localparam int WIDTH_W      = 16;
  localparam int ID_LSB       = 16;
  localparam int ID_W         = 5;
  localparam int TS_W         = 32;

  localparam logic [31:0] DEAD_BEEF = 32'hDEAD_BEEF;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_HIGH = 1'b1
  } ch_state_e;

  typedef struct packed {
    logic [ID_W-1:0]    id;
    logic [TS_W-1:0]    ts;
    logic [WIDTH_W-1:0] width;
  } pulse_rec_t;

  function automatic logic [31:0] head_info(input pulse_rec_t r);
    logic [31:0] w;
    w = '0;
    w[WIDTH_LSB +: WIDTH_W] = r.width;
    w[ID_LSB +: ID_W]       = r.id;
    return w;
  endfunction

endpackage

// File: rtl/darkroom_multi_decoder_channel.sv
// One photodiode channel: sync + edge detect, pulse timing FSM, single-record pending slot.
// Record appears 3 cycles after the falling input edge; a busy slot drops the new record and sets ovf.
module lighthouse_channel
  import darkroom_pkg::*;
#(
  parameter int              MIN_WIDTH = 2,
  parameter logic [ID_W-1:0] ID        = '0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        tick_i,
  input  logic [31:0] timer_i,
  input  logic        enable_i,
  input  logic        sensor_i,
  input  logic        grant_i,
  input  logic        ovf_clr_i,
  output logic        pend_o,
  output pulse_rec_t  rec_o,
  output logic        ch_ovf_o
);

  logic sync1_q, sync2_q, prev_q;
  logic rise, fall;

  ch_state_e          state_q, state_d;
  logic [TS_W-1:0]    ts_q, ts_d;
  logic [WIDTH_W-1:0] width_q, width_d;
  logic               pend_q, pend_d;
  logic               ovf_q, ovf_d;
  pulse_rec_t         rec_q, rec_d;

  // Sync chain resets high so a sensor already lit at reset release never looks like a rise.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= sensor_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise = sync2_q & ~prev_q;
  assign fall = ~sync2_q & prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= CH_IDLE;
      ts_q    <= '0;
      width_q <= '0;
      pend_q  <= 1'b0;
      ovf_q   <= 1'b0;
      rec_q   <= '0;
    end else begin
      state_q <= state_d;
      ts_q    <= ts_d;
      width_q <= width_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      rec_q   <= rec_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ts_d    = ts_q;
    width_d = width_q;
    pend_d  = pend_q & ~grant_i;
    ovf_d   = ovf_q & ~ovf_clr_i;
    rec_d   = rec_q;
    if (!enable_i) begin
      state_d = CH_IDLE;
      pend_d  = 1'b0;
    end else begin
      case (state_q)
        CH_IDLE: begin
          if (rise) begin
            state_d = CH_HIGH;
            ts_d    = timer_i;
            width_d = '0;
          end
        end
        CH_HIGH: begin
          if (fall) begin
            state_d = CH_IDLE;
            // A slot being granted this cycle is free for the new record.
            if (int'(width_q) >= MIN_WIDTH) begin
              if (pend_d) begin
                ovf_d = 1'b1;
              end else begin
                pend_d      = 1'b1;
                rec_d.id    = ID;
                rec_d.ts    = ts_q;
                rec_d.width = width_q;
              end
            end
          end else if (tick_i && (width_q != '1)) begin
            width_d = width_q + 1'b1;
          end
        end
        default: state_d = CH_IDLE;
      endcase
    end
  end

  assign pend_o   = pend_q;
  assign rec_o    = rec_q;
  assign ch_ovf_o = ovf_q;

endmodule

// File: rtl/darkroom_multi_decoder.sv
// Multi-channel lighthouse pulse decoder: round-robin collects channel records into a FIFO behind an Avalon slave.
// Zero-wait reads; HEAD_INFO read pops; a grant into a full FIFO with no pop drops the record and sets FIFO_OVF.
module darkroom_multi_decoder
  import darkroom_pkg::*;
#(
  parameter int NUM_SENSORS = 16,
  parameter int FIFO_DEPTH  = 64,
  parameter int TICK_DIV    = 50,
  parameter int MIN_WIDTH   = 2
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [5:0]             address,
  input  logic                   write,
  input  logic [31:0]            writedata,
  input  logic                   read,
  output logic [31:0]            readdata,
  output logic                   waitrequest,
  input  logic [NUM_SENSORS-1:0] sensor_signal_i,
  output logic                   irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0]          presc_q, presc_d;
  logic [31:0]            timer_q, timer_d;
  logic                   tick;

  logic [NUM_SENSORS-1:0] pend, gnt_vec, ch_ovf, ovf_clr;
  logic [NUM_SENSORS-1:0] enable_q, enable_d;
  pulse_rec_t             ch_rec [NUM_SENSORS];

  logic                   gnt_vld;
  logic [ID_W-1:0]        gnt_id;
  pulse_rec_t             gnt_rec;
  logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;

  pulse_rec_t             mem_q [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]            level_q, level_d;
  logic                   fifo_full, fifo_empty, push, pop, drop;
  logic                   fifo_ovf_q, fifo_ovf_d;
  logic [31:0]            irq_level_q, irq_level_d;
  pulse_rec_t             head;

  assign tick = (presc_q == PW'(TICK_DIV - 1));

  for (genvar g = 0; g < NUM_SENSORS; g++) begin : g_ch
    lighthouse_channel #(
      .MIN_WIDTH(MIN_WIDTH),
      .ID       (ID_W'(g))
    ) u_ch (
      .clk_i    (clock),
      .rst_ni   (reset_n),
      .tick_i   (tick),
      .timer_i  (timer_q),
      .enable_i (enable_q[g]),
      .sensor_i (sensor_signal_i[g]),
      .grant_i  (gnt_vec[g]),
      .ovf_clr_i(ovf_clr[g]),
      .pend_o   (pend[g]),
      .rec_o    (ch_rec[g]),
      .ch_ovf_o (ch_ovf[g])
    );
  end

  // rr_ptr_q is the first id searched, i.e. one past the last granted id.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt_id  = '0;
    gnt_rec = '0;
    for (int i = 0; i < NUM_SENSORS; i++) begin
      idx = (int'(rr_ptr_q) + i) % NUM_SENSORS;
      if (!gnt_vld && pend[idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = ID_W'(idx);
        gnt_rec = ch_rec[idx];
      end
    end
    for (int j = 0; j < NUM_SENSORS; j++) begin
      gnt_vec[j] = gnt_vld && (gnt_id == ID_W'(j));
    end
    rr_ptr_d = rr_ptr_q;
    if (gnt_vld) begin
      rr_ptr_d = (int'(gnt_id) == NUM_SENSORS - 1) ? '0 : gnt_id + 1'b1;
    end
  end

  assign fifo_full  = (level_q == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty = (level_q == '0);
  assign pop        = read && (address == ADDR_HEAD_INFO) && !fifo_empty;
  assign push       = gnt_vld && (!fifo_full || pop);
  assign drop       = gnt_vld && fifo_full && !pop;
  assign head       = mem_q[rd_ptr_q];
  assign ovf_clr    = (write && (address == ADDR_CH_OVF)) ? writedata[NUM_SENSORS-1:0] : '0;

  always_comb begin
    presc_d     = tick ? '0 : presc_q + 1'b1;
    timer_d     = tick ? timer_q + 32'd1 : timer_q;
    wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d     = level_q;
    if (push && !pop) level_d = level_q + 1'b1;
    if (pop && !push) level_d = level_q - 1'b1;
    fifo_ovf_d  = fifo_ovf_q;
    if (write && (address == ADDR_STATUS) && writedata[FIFO_OVF_BIT]) fifo_ovf_d = 1'b0;
    if (drop) fifo_ovf_d = 1'b1;
    enable_d    = (write && (address == ADDR_ENABLE)) ? writedata[NUM_SENSORS-1:0] : enable_q;
    irq_level_d = (write && (address == ADDR_IRQ_LEVEL)) ? writedata : irq_level_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc_q     <= '0;
      timer_q     <= '0;
      rr_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      fifo_ovf_q  <= 1'b0;
      enable_q    <= '1;
      irq_level_q <= 32'd1;
    end else begin
      presc_q     <= presc_d;
      timer_q     <= timer_d;
      rr_ptr_q    <= rr_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      fifo_ovf_q  <= fifo_ovf_d;
      enable_q    <= enable_d;
      irq_level_q <= irq_level_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= gnt_rec;
  end

  always_comb begin
    readdata = DEAD_BEEF;
    case (address)
      ADDR_STATUS: begin
        readdata                = '0;
        readdata[LEVEL_W-1:0]   = LEVEL_W'(level_q);
        readdata[FIFO_OVF_BIT]  = fifo_ovf_q;
      end
      ADDR_HEAD_TS:   if (!fifo_empty) readdata = head.ts;
      ADDR_HEAD_INFO: if (!fifo_empty) readdata = head_info(head);
      ADDR_ENABLE: begin
        readdata                  = '0;
        readdata[NUM_SENSORS-1:0] = enable_q;
      end
      ADDR_CH_OVF: begin
        readdata                  = '0;
        readdata[NUM_SENSORS-1:0] = ch_ovf;
      end
      ADDR_IRQ_LEVEL: readdata = irq_level_q;
      ADDR_TIMER:     readdata = timer_q;
      default:        readdata = DEAD_BEEF;
    endcase
  end

  assign waitrequest = 1'b0;
  assign irq         = (32'(level_q) >= irq_level_q);

endmodule
